// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared widths, stall encodings and divider FSM states for the stall controller.
package pipe_stall_ctrl_pkg;
   localparam int STALL_BUS     = 6;
   localparam int INST_ADDR_BUS = 32;
   localparam logic [INST_ADDR_BUS-1:0] PC_INIT = 32'hBFC0_0000;
   localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_BUS-1:0] STALL_EXE  = 6'b001111;
   localparam logic [STALL_BUS-1:0] STALL_MEM  = 6'b011111;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_t;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: counts consecutive MEM-stage stall cycles and pulses once when the bus looks hung.
module mem_timeout_cnt #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req,
   input  logic i_clr,
   output logic o_pulse
);
   localparam logic [CNT_W-1:0] LIM = CNT_W'(MEM_TIMEOUT);
   logic [CNT_W-1:0] r_cnt;
   logic             w_run;
   assign w_run   = i_req && !i_clr;
   assign o_pulse = w_run && (r_cnt == LIM - 1'b1);
   // Saturating at LIM keeps the pulse single until the request drops.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_cnt <= '0;
      else          r_cnt <= !w_run ? '0 : (r_cnt == LIM) ? r_cnt : r_cnt + 1'b1;
   end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges stage stall requests, exception flushes and divider occupancy
// into the pipeline stall vector, flush strobe and divider handshake.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 8
) (
   input  logic                     cpu_clk_50M,
   input  logic                     cpu_rst_n,
   input  logic                     stallreq_id,
   input  logic                     div_start,
   input  logic                     div_ready,
   input  logic                     stallreq_mem,
   input  logic                     exc_valid,
   input  logic [INST_ADDR_BUS-1:0] exc_pc,
   output logic [STALL_BUS-1:0]     stall,
   output logic                     flush,
   output logic [INST_ADDR_BUS-1:0] flush_pc,
   output logic                     div_go,
   output logic                     div_cancel,
   output logic                     mem_timeout
);
   div_state_t               r_state, w_next;
   logic [INST_ADDR_BUS-1:0] r_flush_pc;
   logic [STALL_BUS-1:0]     w_stall;
   logic                     w_go, w_cancel, w_exe, w_tmo;

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         r_state    <= DIV_IDLE;
         r_flush_pc <= PC_INIT;
      end else begin
         r_state    <= w_next;
         r_flush_pc <= exc_valid ? exc_pc : r_flush_pc;
      end
   end

   // A flush in the same cycle as div_ready still cancels: the exception wins.
   always_comb begin
      w_next   = r_state;
      w_go     = 1'b0;
      w_cancel = 1'b0;
      case (r_state)
         DIV_IDLE: if (div_start && !exc_valid && !stallreq_mem) begin
            w_go   = 1'b1;
            w_next = DIV_BUSY;
         end
         DIV_BUSY: if (exc_valid) begin
            w_cancel = 1'b1;
            w_next   = DIV_IDLE;
         end else if (div_ready) w_next = DIV_DONE;
         default: w_next = DIV_IDLE;
      endcase
   end

   assign w_exe   = (r_state == DIV_IDLE && div_start) || r_state == DIV_BUSY;
   assign w_stall = exc_valid    ? STALL_NONE :
                    stallreq_mem ? STALL_MEM  :
                    w_exe        ? STALL_EXE  :
                    stallreq_id  ? STALL_ID   : STALL_NONE;

   mem_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_tmo (
      .i_clk   (cpu_clk_50M),
      .i_rst_n (cpu_rst_n),
      .i_req   (stallreq_mem),
      .i_clr   (exc_valid),
      .o_pulse (w_tmo)
   );

   // Reset forces every output quiet independent of the request inputs.
   assign stall       = cpu_rst_n ? w_stall : STALL_NONE;
   assign flush       = cpu_rst_n && exc_valid;
   assign flush_pc    = !cpu_rst_n ? PC_INIT : exc_valid ? exc_pc : r_flush_pc;
   assign div_go      = cpu_rst_n && w_go;
   assign div_cancel  = cpu_rst_n && w_cancel;
   assign mem_timeout = cpu_rst_n && w_tmo;
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the MiniMIPS32 five-stage pipeline.
- Merges per-stage stall requests, exception flushes and multi-cycle divider occupancy into the shared stall vector and flush strobe.
- The PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers consume these outputs.
- Tracks divider ownership with a small FSM and detects hung memory accesses with a timeout counter.

Parameters:
- MEM_TIMEOUT, 64: consecutive stallreq_mem cycles before the mem_timeout pulse fires. Legal range is 2..255.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- cpu_clk_50M  in  1  system clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- stallreq_id  in  1  load-use hazard detected in ID.
- div_start  in  1  EXE holds a DIV/DIVU that is not yet started. Level signal.
- div_ready  in  1  divider result valid. One-cycle pulse.
- stallreq_mem  in  1  data bus has not acknowledged a MEM-stage access.
- exc_valid  in  1  MEM stage commits an exception or ERET this cycle.
- exc_pc  in  `INST_ADDR_BUS  handler or EPC target.
- stall  out  `STALL_BUS (6)  bit0 PC, bit1 IF, bit2 ID, bit3 EXE, bit4 MEM, bit5 WB. 1 = `STOP.
- flush  out  1  clear all pipeline registers.
- flush_pc  out  `INST_ADDR_BUS  PC redirect target, valid while flush=1.
- div_go  out  1  start pulse to the divider.
- div_cancel  out  1  abort the in-flight divide.
- mem_timeout  out  1  one-cycle pulse; the MEM stage raises a bus-error exception from it.

Behaviour:
- Reset (cpu_rst_n=0, asynchronous): div FSM goes to IDLE and the timeout counter to 0.
  - Outputs are forced regardless of inputs: stall=6'b000000, flush=0, flush_pc=`PC_INIT, div_go=0, div_cancel=0, mem_timeout=0.
  - Release is synchronous to the next clock edge.
- Div FSM states are IDLE, BUSY and DONE.
  - IDLE: when div_start=1, exc_valid=0 and stallreq_mem=0, pulse div_go (combinational) and go to BUSY.
  - BUSY: div_ready=1 -> DONE. exc_valid=1 -> pulse div_cancel and go to IDLE. This applies even if div_ready=1 in the same cycle, because flush wins.
  - DONE: lasts one cycle, during which EXE captures the result. Then IDLE. div_start is ignored in DONE so the same divide is not restarted.
  - A new div_start in the cycle after DONE is a new instruction and restarts normally.
- stallreq_exe is internal, combinational, and equals (state==IDLE && div_start) || state==BUSY.
- Stall priority, resolved combinationally each cycle:
  1. exc_valid=1 -> stall=000000, flush=1, flush_pc=exc_pc. The flush lasts exactly the cycles exc_valid is high.
  2. stallreq_mem=1 -> stall=011111. WB continues; a bubble enters WB.
  3. stallreq_exe=1 -> stall=001111. A bubble enters MEM.
  4. stallreq_id=1 -> stall=000111. A bubble enters EXE.
  5. Otherwise stall=000000.
  - The stall vector is always a contiguous run of ones from bit 0. No other pattern is ever driven.
- Outside a flush, flush_pc holds its last driven value.
- Timeout counter:
  - Increments each cycle stallreq_mem=1 and exc_valid=0. Clears to 0 when stallreq_mem=0 or exc_valid=1.
  - When the count equals MEM_TIMEOUT-1 with stallreq_mem still 1, mem_timeout=1 for that cycle only.
  - After the pulse the counter saturates at MEM_TIMEOUT and does not re-pulse until stallreq_mem drops.
  - Counter arithmetic is unsigned CNT_W-bit and never wraps.
- Simultaneous events:
  - stallreq_mem during BUSY: the FSM keeps waiting, and the stall shows 011111.
  - div_ready arriving while stallreq_mem=1: the FSM still enters DONE. The divider holds its result until div_start falls, so capture is deferred, not lost.
- Mid-operation reset during BUSY: the FSM returns to IDLE asynchronously. div_cancel is not asserted on reset; the divider has its own reset.
- Latency: all outputs are combinational on inputs plus registered state. Zero-cycle request-to-stall.

Decomposition:
- define.vh gains the following; all other constants reuse existing definitions (`STOP, `NOSTOP, `STALL_BUS, `PC_INIT, `INST_ADDR_BUS):
  - `DIV_IDLE=2'b00, `DIV_BUSY=2'b01, `DIV_DONE=2'b10.
  - `STALL_NONE=6'b000000, `STALL_ID=6'b000111, `STALL_EXE=6'b001111, `STALL_MEM=6'b011111.
- One natural sub-module: mem_timeout_cnt, containing the counter, saturation and pulse logic.

Test Plan:
- Reset mid-BUSY: assert cpu_rst_n=0 with no clock edge -> stall=000000, flush=0, state IDLE, div_go=0 immediately.
- stallreq_id=1 for 1 cycle -> stall=000111 that cycle only, then 000000. Also apply stallreq_id=1 and stallreq_exe=1 together -> stall=001111.
- Divide sequence:
  - Stimulus: div_start=1 from cycle 0; div_ready pulse at cycle 33; div_start drops at cycle 35.
  - Required: div_go pulse at cycle 0; stall=001111 for cycles 0..33; state DONE at cycle 34 with stall=000000; no second div_go.
- Exception during BUSY: exc_valid=1, exc_pc=0xBFC00380 in the same cycle as div_ready -> flush=1, flush_pc=0xBFC00380, stall=000000, div_cancel=1, next state IDLE.
- Memory hang with MEM_TIMEOUT=4: stallreq_mem=1 held 10 cycles -> stall=011111 throughout; mem_timeout=1 only on cycle 3. Dropping and re-raising stallreq_mem -> next pulse 4 cycles later.
- exc_valid=1 while stallreq_mem=1 at count 2 -> flush=1, stall=000000, counter clears; mem_timeout never fires.
